dice_roll_ci: RTL and testbench
===============================

DICE_ROLL_CI -- requirements
Module: dice_roll_ci

Interface
REQ-001 SHALL have parameter ENTROPY_W, default 7: bits per raw entropy sample, legal range 3..10.
REQ-002 SHALL have parameter MAX_DICE, default 8: maximum dice per roll, legal range 1..16.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port clk_en, input, 1: global enable; all state frozen while low.
REQ-006 SHALL have port start, input, 1: single-cycle request pulse.
REQ-007 SHALL have port dataa, input, 32: [7:0] = sides N.
REQ-008 SHALL have port datab, input, 32: [4:0] = dice count K.
REQ-009 SHALL have port i_entropy, input, 1: serial raw random bit, one per enabled cycle.
REQ-010 SHALL have port result, output, 32: roll sum and status.
REQ-011 SHALL have port done, output, 1: one-cycle completion strobe.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, COLLECT, CHECK, DONE; transitions occur only on enabled cycles (clk_en=1).
REQ-013 In IDLE, start=1 SHALL latch N and K, clear the sum, clear the dice counter and clear the reject counter, then enter SETUP; start in any other state SHALL be ignored.
REQ-014 Legality: N<2, K=0 or K>MAX_DICE SHALL make SETUP go to DONE with result[31]=1 and result[30:0]=0.
REQ-015 SETUP (1 cycle) SHALL compute limit = 2^ENTROPY_W - (2^ENTROPY_W mod N), then enter COLLECT with the bit counter at 0.
REQ-016 COLLECT SHALL shift sample = {sample[ENTROPY_W-2:0], i_entropy} each enabled cycle and enter CHECK after exactly ENTROPY_W shifts.
REQ-017 CHECK, sample >= limit: SHALL reject, increment the reject counter (saturating at 255) and return to COLLECT.
REQ-018 CHECK, sample < limit: SHALL add (sample mod N)+1 to the sum and increment the dice counter. It SHALL enter DONE when the dice counter reaches K, otherwise COLLECT.
REQ-019 Sum register width SHALL be ENTROPY_W+5 bits; no overflow is possible within the legal parameter ranges.
REQ-020 DONE SHALL assert done=1 for exactly one enabled cycle, load result, then return to IDLE.
REQ-021 result SHALL hold: [31] error, [15:0] sum zero-extended, other bits 0 unless REQ-027 applies.
REQ-022 result SHALL hold its value until the next DONE.
REQ-023 Best-case latency (clk_en=1 throughout, no rejects) SHALL be K*(ENTROPY_W+1)+2 cycles from the start edge to the done cycle. This is 10 for ENTROPY_W=7, K=1.
REQ-024 clk_en low mid-roll SHALL stall every state, counter and shift bit; the roll SHALL resume unchanged when clk_en returns high. done SHALL stay 1 while stalled in DONE.

Reset
REQ-025 reset_n=0 SHALL force IDLE asynchronously, with done=0, result=0 and all counters, sample, sum and limit at 0, including mid-roll. No done SHALL be produced for an aborted roll.
REQ-026 After reset_n deasserts, the first start SHALL be accepted on the first enabled edge.

Configuration
REQ-027 With macro DICE_ROLL_REJECT_CNT_EN defined, result[23:16] SHALL carry the saturating reject count of the completed roll. Without the macro, result[23:16] SHALL be 0 and the reject counter SHALL not be synthesized.

Verification
REQ-028 V1: N=6, K=1, bits 0000101 -> done 10 cycles after start; result=0x00000006.
REQ-029 V2: N=6, K=2, bits 1111111 (127>=limit 126, reject), 0000101, 0000000 -> result[15:0]=7. Result = 0x00010007 with the macro, 0x00000007 without.
REQ-030 V3: N=1, K=1 -> done 2 cycles after start; result=0x80000000. Repeat with N=6, K=0 and with N=6, K=9 for the same response.
REQ-031 V4: N=6, K=1, clk_en low for 5 cycles mid-COLLECT -> done 15 cycles after start; same result as V1; second start pulse while busy ignored.
REQ-032 V5: reset_n pulsed low during COLLECT -> done=0 and result=0 immediately, no done afterwards; next start with N=6, K=1 and bits 0000101 gives result=6 at the V1 latency.

Source files
------------

// File: rtl/dice_roll_ci.sv
// dice_roll_ci: rejection-sampled roll of K fair N-sided dice from a serial entropy stream.
// Optional: define DICE_ROLL_REJECT_CNT_EN to report the reject count in result[23:16].
module dice_roll_ci #(
    parameter int ENTROPY_W = 7,
    parameter int MAX_DICE  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    input  logic        i_entropy,
    output logic [31:0] result,
    output logic        done
);

    localparam int SW = ENTROPY_W + 5;
    localparam int LW = ENTROPY_W + 1;
    localparam logic [15:0] RANGE16 = 16'(1) << ENTROPY_W;
    localparam logic [5:0]  MAXK    = 6'(MAX_DICE);
    localparam logic [3:0]  LASTBIT = 4'(ENTROPY_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        COLLECT,
        CHECK,
        DONE
    } state_t;

    state_t                 state;
    logic [7:0]             n_q;
    logic [4:0]             k_q;
    logic [ENTROPY_W-1:0]   sample;
    logic [3:0]             bit_cnt;
    logic [4:0]             dice_cnt;
    logic [SW-1:0]          sum_q;
    logic [LW-1:0]          limit_q;
    logic                   err_q;
    logic [7:0]             rej_field;

`ifdef DICE_ROLL_REJECT_CNT_EN
    logic [7:0]             rej_cnt;
    assign rej_field = rej_cnt;
`else
    assign rej_field = 8'd0;
`endif

    // Divisor is forced nonzero so the modulo never divides by zero;
    // an N of zero is rejected as illegal before it is ever used.
    logic [15:0] n16;
    logic [15:0] samp16;
    logic [15:0] limit16;
    logic [15:0] limit_next;
    logic [15:0] mod16;
    logic [4:0]  dice_next;
    logic        illegal;

    assign n16        = (n_q == 8'd0) ? 16'd1 : {8'd0, n_q};
    assign samp16     = 16'(sample);
    assign limit16    = 16'(limit_q);
    assign limit_next = RANGE16 - (RANGE16 % n16);
    assign mod16      = samp16 % n16;
    assign dice_next  = dice_cnt + 5'd1;
    assign illegal    = (n_q < 8'd2) || (k_q == 5'd0) ||
                        ({1'b0, k_q} > MAXK);

    logic unused_bits;
    assign unused_bits = ^{dataa[31:8], datab[31:5],
                           mod16[15:SW], limit_next[15:LW]};

    // Roll sequencer: all state advances only on enabled edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            n_q      <= '0;
            k_q      <= '0;
            sample   <= '0;
            bit_cnt  <= '0;
            dice_cnt <= '0;
            sum_q    <= '0;
            limit_q  <= '0;
            err_q    <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
`ifdef DICE_ROLL_REJECT_CNT_EN
            rej_cnt  <= '0;
`endif
        end else if (clk_en) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_q      <= dataa[7:0];
                        k_q      <= datab[4:0];
                        sum_q    <= '0;
                        dice_cnt <= '0;
                        err_q    <= 1'b0;
`ifdef DICE_ROLL_REJECT_CNT_EN
                        rej_cnt  <= '0;
`endif
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (illegal) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        limit_q <= limit_next[LW-1:0];
                        bit_cnt <= '0;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    sample <= {sample[ENTROPY_W-2:0], i_entropy};
                    if (bit_cnt == LASTBIT) begin
                        bit_cnt <= '0;
                        state   <= CHECK;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (samp16 >= limit16) begin
`ifdef DICE_ROLL_REJECT_CNT_EN
                        if (rej_cnt != 8'hFF) rej_cnt <= rej_cnt + 8'd1;
`endif
                        state <= COLLECT;
                    end else begin
                        sum_q    <= sum_q + mod16[SW-1:0] + SW'(1);
                        dice_cnt <= dice_next;
                        state    <= (dice_next == k_q) ? DONE : COLLECT;
                    end
                end
                DONE: begin
                    done   <= 1'b1;
                    result <= {err_q, 7'd0, rej_field, 16'(sum_q)};
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dice_roll_ci.sv
// tb_dice_roll_ci: random and directed rolls checked against a
// transaction-level dice model, compared every cycle.
module tb_dice_roll_ci;

    localparam int W    = 7;
    localparam int MAXD = 8;
    localparam int RNG  = 1 << W;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        clk_en = 1'b0;
    logic        start = 1'b0;
    logic        i_entropy = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [31:0] result;
    logic        done;

    dice_roll_ci #(.ENTROPY_W(W), .MAX_DICE(MAXD)) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start),
        .dataa(dataa), .datab(datab), .i_entropy(i_entropy),
        .result(result), .done(done)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    bit          chk_on = 0;
    bit          exp_done = 0;
    logic [31:0] exp_result = '0;
    bit          busy = 0;
    int          e = 0;
    int          done_edge = 0;
    logic [31:0] r_exp = '0;
    bit          rel_pending = 0;
    bit          stream[$];
    int          samp[$];

    // Every-cycle comparison against the model's expectation.
    always @(negedge clk) begin
        if (chk_on) begin
            vectors++;
            if (done !== exp_done || result !== exp_result) begin
                miscompares++;
                $display("FAIL cycle t=%0t: done=%0b result=%h, required done=%0b result=%h",
                         $time, done, result, exp_done, exp_result);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit st, input bit en, input bit ent,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (rel_pending) begin
            reset_n = 1'b1;
            rel_pending = 0;
        end
        start = st; clk_en = en; i_entropy = ent; dataa = a; datab = b;
        @(posedge clk);
        if (en) begin
            exp_done = 0;
            if (busy) begin
                e++;
                if (e == done_edge) begin
                    exp_done = 1;
                    exp_result = r_exp;
                    busy = 0;
                end
            end
        end
    endtask

    function automatic int lim_of(input int n);
        return RNG - (RNG % ((n < 1) ? 1 : n));
    endfunction

    task automatic gen(input int n, input int k);
        int acc = 0;
        int lim = lim_of(n);
        samp.delete();
        while (acc < k) begin
            if (lim < RNG && $urandom_range(0, 3) == 0)
                samp.push_back(int'($urandom_range(lim, RNG - 1)));
            else begin
                samp.push_back(int'($urandom_range(0, lim - 1)));
                acc++;
            end
        end
    endtask

    task automatic roll(input int n, input int k, input bit rnd_en,
                        input int stall_at, input int stall_len,
                        input int extra_at, input int abort_at,
                        output int lat);
        int sum = 0, rej = 0, acc = 0, cyc = 0;
        int lim = lim_of(n);
        bit ill = (n < 2) || (k == 0) || (k > MAXD);
        bit en, ent, xs;
        stream.delete();
        stream.push_back(1'($urandom));
        stream.push_back(1'($urandom));
        if (!ill) begin
            foreach (samp[i]) begin
                if (acc == k) break;
                for (int b = W - 1; b >= 0; b--)
                    stream.push_back(((samp[i] >> b) & 1) != 0);
                stream.push_back(1'($urandom));
                if (samp[i] >= lim) begin
                    if (rej < 255) rej++;
                end else begin
                    sum += samp[i] % n + 1;
                    acc++;
                end
            end
        end
        done_edge = stream.size();
        r_exp = 32'(sum);
`ifdef DICE_ROLL_REJECT_CNT_EN
        r_exp = r_exp | (32'(rej) << 16);
`endif
        if (ill) r_exp = 32'h8000_0000;
        busy = 1;
        e = -1;
        step(1, 1, stream[0], {24'($urandom), 8'(n)}, {27'($urandom), 5'(k)});
        lat = 0;
        while (busy && cyc < 3000) begin
            cyc++;
            if (rnd_en) en = ($urandom_range(0, 3) != 0);
            else en = !(cyc >= stall_at && cyc < stall_at + stall_len);
            ent = (e + 1 < stream.size()) ? stream[e + 1] : 1'($urandom);
            xs = (cyc == extra_at) || (rnd_en && $urandom_range(0, 15) == 0);
            step(xs, en, ent, $urandom, $urandom);
            if (cyc == abort_at) begin
                #2 reset_n = 1'b0;
                #1;
                chk("async reset done", 32'(done), 32'd0);
                chk("async reset result", result, 32'd0);
                busy = 0;
                exp_done = 0;
                exp_result = '0;
                rel_pending = 1;
                lat = cyc;
                return;
            end
        end
        lat = cyc;
        if (busy) begin
            miscompares++;
            $display("FAIL timeout: roll n=%0d k=%0d not finished in %0d cycles", n, k, cyc);
            busy = 0;
        end
    endtask

    initial begin
        int lat, n, k;
        #1 reset_n = 1'b0;
        #1;
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        chk_on = 1;
        rel_pending = 1;

        samp = '{5};
        roll(6, 1, 0, 0, 0, 0, 0, lat);
        chk("v1 latency", 32'(lat), 32'd10);
        chk("v1 model result", r_exp, 32'h6);

        samp = '{127, 5, 0};
        roll(6, 2, 0, 0, 0, 0, 0, lat);
        chk("v2 latency", 32'(lat), 32'd26);
`ifdef DICE_ROLL_REJECT_CNT_EN
        chk("v2 model result", r_exp, 32'h0001_0007);
`else
        chk("v2 model result", r_exp, 32'h0000_0007);
`endif

        samp.delete();
        roll(1, 1, 0, 0, 0, 0, 0, lat);
        chk("v3 n1 latency", 32'(lat), 32'd2);
        chk("v3 n1 model result", r_exp, 32'h8000_0000);
        roll(6, 0, 0, 0, 0, 0, 0, lat);
        chk("v3 k0 latency", 32'(lat), 32'd2);
        roll(6, 9, 0, 0, 0, 0, 0, lat);
        chk("v3 k9 latency", 32'(lat), 32'd2);

        samp = '{5};
        roll(6, 1, 0, 4, 5, 3, 0, lat);
        chk("v4 latency", 32'(lat), 32'd15);
        chk("v4 model result", r_exp, 32'h6);

        samp = '{5};
        roll(6, 1, 0, 0, 0, 0, 5, lat);
        for (int i = 0; i < 12; i++) step(0, 1, 1'($urandom), '0, '0);
        samp = '{5};
        roll(6, 1, 0, 0, 0, 0, 0, lat);
        chk("v5 latency", 32'(lat), 32'd10);

        for (int r = 0; r < 60; r++) begin
            n = int'($urandom_range(2, RNG));
            k = int'($urandom_range(1, MAXD));
            case ($urandom_range(0, 9))
                0: n = int'($urandom_range(0, 1));
                1: k = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAXD + 1, 31));
                default: ;
            endcase
            gen(n, k);
            roll(n, k, 1, 0, 0, 0, 0, lat);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                step(0, 1'($urandom), 1'($urandom), '0, '0);
        end

        for (int i = 0; i < 4; i++) step(0, 1, 0, '0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
